// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encodings and datapath width.
package alu_pkg;
    localparam int ALU_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } seq_state_t;
endpackage

// File: rtl/carry_lookahead_adder32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module CarryLookaheadAdder32Bit (
    output logic [31:0] result,
    output logic        c_out,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in
);
    logic [31:0] g, p, ci;
    logic [7:0]  gg, pg;
    logic        carry;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        gg = '0;
        pg = '0;
        for (int k = 0; k < 8; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pg[k] = &p[4*k +: 4];
        end
    end

    // Bit carries inside a group come straight from the group carry-in.
    always_comb begin
        ci    = '0;
        carry = c_in;
        for (int k = 0; k < 8; k++) begin
            ci[4*k]   = carry;
            ci[4*k+1] = g[4*k] | (p[4*k] & carry);
            ci[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                      | (p[4*k+1] & p[4*k] & carry);
            ci[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                      | (p[4*k+2] & p[4*k+1] & g[4*k])
                      | (p[4*k+2] & p[4*k+1] & p[4*k] & carry);
            carry     = gg[k] | (pg[k] & carry);
        end
    end

    assign result = p ^ ci;
    assign c_out  = carry;
endmodule

// File: rtl/alu_mult_sequencer.sv
// Unsigned multi-cycle multiplier: WIDTH shift-and-add iterations through one shared adder.
module alu_mult_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    seq_state_t       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             sum_co;

    assign addend = lo[0] ? mcand : '0;

    CarryLookaheadAdder32Bit u_cla (
        .result (sum),
        .c_out  (sum_co),
        .a      (hi),
        .b      (addend),
        .c_in   (1'b0)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            count <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    // Carry-out lands in hi's MSB: {c_out, sum, lo} >> 1.
                    hi    <= {sum_co, sum[WIDTH-1:1]};
                    lo    <= {sum[0], lo[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        mcand <= multiplicand;
                        hi    <= '0;
                        lo    <= multiplier;
                        count <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Scoreboard bench: stimulus pushes exact products with due cycles; a negedge monitor checks.
module tb_alu_mult_sequencer;
    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH;

    typedef struct {
        logic [63:0] prod;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0, reset_n = 1'b1, start = 1'b0;
    logic [31:0] multiplicand = '0, multiplier = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          errors = 0, checks = 0, cyc = 0;
    bit          mon_en = 1'b0;
    logic        eb, ed;
    logic [63:0] last_prod = '0;
    exp_t        sb[$];

    alu_mult_sequencer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: busy/done timing and product come purely from the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
                checks++;
                errors++;
                $display("FAIL done_missed: got no done by cycle %0d expected at %0d", cyc, sb[0].done_cyc);
                void'(sb.pop_front());
            end
            eb = (sb.size() > 0) && (cyc < sb[0].done_cyc);
            ed = (sb.size() > 0) && (cyc == sb[0].done_cyc);
            check("busy", 64'(busy), 64'(eb));
            check("done", 64'(done), 64'(ed));
            if (ed) begin
                check("product", {hi, lo}, sb[0].prod);
                last_prod = sb[0].prod;
                void'(sb.pop_front());
            end else if (sb.size() == 0) begin
                check("held", {hi, lo}, last_prod);
            end
        end
    end

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.prod     = 64'(a) * 64'(b);
        e.done_cyc = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; multiplicand = a; multiplier = b;
        @(posedge clk); #1;
        push_exp(a, b);
        start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
    endtask

    // Raise start in the DONE cycle so the next op begins without an IDLE cycle.
    task automatic issue_b2b(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        @(negedge clk);
        while (!done && n < 60) begin @(negedge clk); n++; end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL b2b_wait: got done=0 expected done=1 within 60 cycles");
        end
        start = 1'b1; multiplicand = a; multiplier = b;
        @(posedge clk); #1;
        push_exp(a, b);
        check("b2b_busy", 64'(busy), 64'd1);
        start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
    endtask

    task automatic poke_start(input int after);
        repeat (after) @(negedge clk);
        start = 1'b1; multiplicand = $urandom; multiplier = $urandom;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic [31:0] a, b;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        issue(32'd3, 32'd5);                  wait_drain();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_drain();
        issue(32'h1234_5678, 32'd0);          wait_drain();

        // Start during RUN is ignored.
        issue(32'd7, 32'd9);
        poke_start(9);
        wait_drain();

        // Asynchronous reset mid-run discards the partial product.
        issue(32'd1000, 32'd1000);
        repeat (14) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_hilo", {hi, lo}, 64'd0);
        sb.delete();
        last_prod = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        issue(32'd2, 32'd3);                  wait_drain();

        // Back-to-back through the DONE cycle.
        issue(32'h0001_0000, 32'h0001_0000);
        issue_b2b(32'h0001_0000, 32'h0001_0000);
        wait_drain();

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(0, 255);
                default: b = $urandom;
            endcase
            if (sb.size() != 0 && $urandom_range(0, 2) == 0) begin
                issue_b2b(a, b);
            end else begin
                wait_drain();
                repeat ($urandom_range(0, 3)) @(negedge clk);
                issue(a, b);
            end
            if ($urandom_range(0, 2) == 0) poke_start($urandom_range(1, 20));
        end
        wait_drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
